store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the core's data-memory port (MemWrite/DataAdr/WriteData)
//  and a data RAM that may stall writes.
//  Stores are queued in a FIFO and retired to RAM in order, one per cycle, whenever mem_ready is high.
//  Loads read RAM directly; loads whose word address matches a queued store are forwarded (or stalled).
//  The core sees a single stall line.
// PARAMETERS
//  DEPTH  4   store entries; power of two, >=2
//  AW     32  address width (word address = addr[AW-1:2])
//  DW     32  data width
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  st_valid   in   1   core issues a store this cycle (MemWrite)
//  st_addr    in   AW  store byte address (DataAdr)
//  st_data    in   DW  store data (WriteData)
//  ld_valid   in   1   core issues a load this cycle
//  ld_addr    in   AW  load byte address
//  ld_data    out  DW  load result to core (ReadData)
//  stall      out  1   core must hold PC/instruction this cycle
//  mem_we     out  1   RAM write strobe
//  mem_waddr  out  AW  RAM write address (head entry)
//  mem_wdata  out  DW  RAM write data (head entry)
//  mem_ready  in   1   RAM accepts write this cycle
//  mem_raddr  out  AW  RAM read address (= ld_addr, combinational)
//  mem_rdata  in   DW  RAM read data, combinational
//  empty      out  1   no stores pending
// BEHAVIOUR
//  - State: entry array, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count 0..DEPTH.
//  - Reset (async): count=0, head=tail=0, entries' valid cleared.
//    Outputs: mem_we=0, empty=1, stall=0, ld_data=mem_rdata.
//  - full = (count==DEPTH). Push on posedge when st_valid & ~full: write entry[tail], tail++.
//  - Push when full is refused and raises stall. This holds even if a pop occurs the same cycle;
//    there is no same-cycle slot reuse. The core retries the store next cycle.
//  - Drain: mem_we=~empty; mem_waddr/mem_wdata = entry[head] (combinational from regs).
//    Pop on posedge when mem_we & mem_ready: head++.
//  - Simultaneous push+pop (count not full): count unchanged, both pointers advance.
//  - Write latency: a store is visible to RAM at the earliest one cycle after issue
//    (entry registered, then drained).
//  - Store ordering to RAM is strictly FIFO. Duplicate addresses are not merged.
//  - Load match: compare ld_addr[AW-1:2] against every valid entry.
//    The youngest match (closest to tail) wins.
//  - The comparison includes an entry being popped this cycle. It excludes the store being pushed
//    this cycle; a same-cycle ld+st is not a legal single-cycle instruction.
//  - No match: ld_data = mem_rdata.
//  - stall = (st_valid & full) | ld_stall, where ld_stall is defined by the feature below.
//  - reset asserted mid-drain: queued stores are discarded and mem_we drops immediately.
// CONFIGURATION
//  - Macro STORE_BUFFER_FWD_EN.
//  - Defined: on a match, ld_data = youngest matching entry data; ld_stall=0. Zero-latency forwarding.
//  - Undefined: on a match, ld_stall=1 and ld_data=mem_rdata.
//    The stall holds until no matching entry remains, i.e. those entries have drained.
//    There is no forwarding mux.
// STRUCTURE
//  - Package store_buffer_pkg:
//    sb_entry_t struct {logic valid; logic [AW-3:0] waddr; logic [DW-1:0] data};
//    localparam SB_PTR_W = $clog2(DEPTH).
//  - Sub-module sb_match: combinational youngest-match priority search over the entries.
//    Inputs: entries, head, count, load word address. Outputs: hit, hit_idx.
// TESTING
//  - Reset then idle:
//    empty=1, mem_we=0, stall=0; ld_addr=0x40 -> mem_raddr=0x40, ld_data=mem_rdata.
//  - Single store, mem_ready=1:
//    st 0x64<=7 -> next cycle mem_we=1, mem_waddr=0x64, mem_wdata=7; following cycle empty=1.
//  - Fill, mem_ready=0:
//    4 stores to 0x00,0x04,0x08,0x0C -> count=4; a 5th store raises stall.
//    Then mem_ready=1 -> RAM writes drain in order 0x00..0x0C; the 5th store is accepted once not full.
//  - Forward, mem_ready=0:
//    st 0x60<=3, st 0x60<=9, ld 0x62 -> FWD_EN: ld_data=9, stall=0.
//    Without FWD_EN: stall=1 until both entries drain, then ld_data=mem_rdata.
//  - Pointer wrap: 10 stores with mem_ready toggling every cycle -> all 10 RAM writes in issue order,
//    no loss or duplication.
//  - Reset with 3 entries pending -> mem_we=0 and empty=1 immediately (async); no further RAM writes.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the posted-write store buffer.
// Entry layout holds the word address only; byte offset bits are dropped at push.
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;
   localparam int SB_PTR_W = $clog2(SB_DEPTH);

   typedef struct packed {
      logic              valid;
      logic [SB_AW-3:0]  waddr;
      logic [SB_DW-1:0]  data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_sb_match.sv
// Youngest-match search of a load word address over the queued store entries.
// Walks entries oldest to youngest from head, so the last hit found is the youngest.
module sb_match
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = SB_PTR_W
) (
   input  sb_entry_t          entries_i [DEPTH],
   input  logic [PTR_W-1:0]   head_i,
   input  logic [PTR_W:0]     count_i,
   input  logic [SB_AW-3:0]   ld_waddr_i,
   output logic               hit_o,
   output logic [PTR_W-1:0]   hit_idx_o
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      hit_o     = 1'b0;
      hit_idx_o = '0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + PTR_W'(k);
         if ((PTR_W+1)'(k) < count_i && entries_i[idx].valid &&
             entries_i[idx].waddr == ld_waddr_i) begin
            hit_o     = 1'b1;
            hit_idx_o = idx;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and a stallable RAM; retires one store per cycle.
// STORE_BUFFER_FWD_EN selects load forwarding from queued stores; otherwise matching loads stall.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   output logic [DW-1:0] ld_data,
   output logic          stall,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_rdata,
   output logic          empty
);

   localparam int PTR_W = $clog2(DEPTH);

   sb_entry_t        entries_q [DEPTH];
   sb_entry_t        entries_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   logic             full;
   logic             push;
   logic             pop;
   logic             hit;
   logic [PTR_W-1:0] hit_idx;
   logic             ld_hit;
   logic             ld_stall;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);

   // A full buffer refuses the push even if the head retires this cycle.
   assign push  = st_valid & ~full;
   assign pop   = ~empty & mem_ready;

   assign mem_we    = ~empty;
   assign mem_waddr = {entries_q[head_q].waddr, 2'b00};
   assign mem_wdata = entries_q[head_q].data;
   assign mem_raddr = ld_addr;

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (pop) begin
         entries_d[head_q].valid = 1'b0;
         head_d                  = head_q + 1'b1;
      end
      if (push) begin
         entries_d[tail_q] = '{valid: 1'b1, waddr: st_addr[AW-1:2], data: st_data};
         tail_d            = tail_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         entries_q <= entries_d;
      end
   end

   sb_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_match (
      .entries_i  (entries_q),
      .head_i     (head_q),
      .count_i    (count_q),
      .ld_waddr_i (ld_addr[AW-1:2]),
      .hit_o      (hit),
      .hit_idx_o  (hit_idx)
   );

   assign ld_hit = ld_valid & hit;

`ifdef STORE_BUFFER_FWD_EN
   assign ld_stall = 1'b0;
   assign ld_data  = ld_hit ? entries_q[hit_idx].data : mem_rdata;
`else
   // Matching load waits until every matching store has drained to RAM.
   assign ld_stall = ld_hit;
   assign ld_data  = mem_rdata;

   logic unused_hit_idx;
   assign unused_hit_idx = ^hit_idx;
`endif

   assign stall = (st_valid & full) | ld_stall;

   logic unused_byte_bits;
   assign unused_byte_bits = ^{st_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer plus multi-cycle wrap and reset sequences.
// Expected load results follow STORE_BUFFER_FWD_EN the same way the design build does.
module tb_store_buffer;

`ifdef STORE_BUFFER_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic        stall;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .st_valid  (st_valid),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .stall     (stall),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .empty     (empty)
   );

   typedef struct packed {
      logic        st_v;
      logic [31:0] st_a;
      logic [31:0] st_d;
      logic        ld_v;
      logic [31:0] ld_a;
      logic        rdy;
      logic [31:0] rdata;
      logic        e_stall;
      logic        e_we;
      logic [31:0] e_waddr;
      logic [31:0] e_wdata;
      logic        e_empty;
      logic [31:0] e_ld;
   } vec_t;

   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      st_valid  = 1'b0;
      st_addr   = '0;
      st_data   = '0;
      ld_valid  = 1'b0;
      ld_addr   = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
   endtask

   initial begin
      logic [31:0] fwd_ld;
      int issued;
      int wr;
      reset = 1'b1;
      drive_idle();

      // single store, retire next cycle
      //                st   addr      data      ld   addr      rdy  rdata     stall we  waddr     wdata     empty ld_data
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'h40, 1'b1, 32'h11, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h11});
      vecs.push_back('{1'b1, 32'h64, 32'h7, 1'b0, 32'h00, 1'b1, 32'h12, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h12});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b0, 32'h00, 1'b1, 32'h13, 1'b0, 1'b1, 32'h64, 32'h7,  1'b0, 32'h13});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b0, 32'h00, 1'b1, 32'h14, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h14});
      // fill with RAM stalled, 5th store refused even when head pops
      vecs.push_back('{1'b1, 32'h00, 32'h10, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h0});
      vecs.push_back('{1'b1, 32'h04, 32'h11, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 32'h10, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h08, 32'h12, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 32'h10, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h0C, 32'h13, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 32'h10, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h10, 32'h14, 1'b0, 32'h00, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 32'h10, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h10, 32'h14, 1'b0, 32'h00, 1'b1, 32'h0, 1'b1, 1'b1, 32'h00, 32'h10, 1'b0, 32'h0});
      vecs.push_back('{1'b1, 32'h10, 32'h14, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 32'h11, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0,  1'b0, 32'h00, 1'b1, 32'h0, 1'b0, 1'b1, 32'h04, 32'h11, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0,  1'b0, 32'h00, 1'b1, 32'h0, 1'b0, 1'b1, 32'h08, 32'h12, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0,  1'b0, 32'h00, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0C, 32'h13, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0,  1'b0, 32'h00, 1'b1, 32'h0, 1'b0, 1'b1, 32'h10, 32'h14, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0,  1'b0, 32'h00, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,  1'b1, 32'h0});
      // two stores to same word, then load of that word (youngest = 9)
      fwd_ld = FWD ? 32'h9 : 32'h55;
      vecs.push_back('{1'b1, 32'h60, 32'h3, 1'b0, 32'h00, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'h0});
      vecs.push_back('{1'b1, 32'h60, 32'h9, 1'b0, 32'h00, 1'b0, 32'h0,  1'b0, 1'b1, 32'h60, 32'h3, 1'b0, 32'h0});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'h70, 1'b0, 32'h77, 1'b0, 1'b1, 32'h60, 32'h3, 1'b0, 32'h77});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'h62, 1'b0, 32'h55, !FWD, 1'b1, 32'h60, 32'h3, 1'b0, fwd_ld});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'h62, 1'b1, 32'h55, !FWD, 1'b1, 32'h60, 32'h3, 1'b0, fwd_ld});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'h62, 1'b1, 32'h55, !FWD, 1'b1, 32'h60, 32'h9, 1'b0, fwd_ld});
      vecs.push_back('{1'b0, 32'h00, 32'h0, 1'b1, 32'h62, 1'b0, 32'h55, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'h55});

      #12;
      mem_rdata = 32'hCAFE_0001;
      ld_valid  = 1'b1;
      ld_addr   = 32'h40;
      #1;
      check("rst_empty", {31'b0, empty}, 32'd1);
      check("rst_we", {31'b0, mem_we}, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      check("rst_ld_data", ld_data, 32'hCAFE_0001);
      cyc();
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         st_valid  = vecs[i].st_v;
         st_addr   = vecs[i].st_a;
         st_data   = vecs[i].st_d;
         ld_valid  = vecs[i].ld_v;
         ld_addr   = vecs[i].ld_a;
         mem_ready = vecs[i].rdy;
         mem_rdata = vecs[i].rdata;
         #1;
         check($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
         check($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
         check($sformatf("v%0d_empty", i), {31'b0, empty}, {31'b0, vecs[i].e_empty});
         check($sformatf("v%0d_ld_data", i), ld_data, vecs[i].e_ld);
         check($sformatf("v%0d_raddr", i), mem_raddr, vecs[i].ld_a);
         if (vecs[i].e_we) begin
            check($sformatf("v%0d_waddr", i), mem_waddr, vecs[i].e_waddr);
            check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
         end
         cyc();
      end

      // pointer wrap: 10 stores, RAM ready every other cycle, retry on stall
      drive_idle();
      issued = 0;
      wr = 0;
      for (int c = 0; c < 200 && wr < 10; c++) begin
         st_valid  = (issued < 10);
         st_addr   = 32'h100 + 32'(issued) * 4;
         st_data   = 32'hD0 + 32'(issued);
         mem_ready = c[0];
         #1;
         if (mem_we && mem_ready) begin
            check($sformatf("wrap_waddr%0d", wr), mem_waddr, 32'h100 + 32'(wr) * 4);
            check($sformatf("wrap_wdata%0d", wr), mem_wdata, 32'hD0 + 32'(wr));
            wr++;
         end
         if (st_valid && !stall) issued++;
         cyc();
      end
      check("wrap_writes", 32'(wr), 32'd10);
      check("wrap_issued", 32'(issued), 32'd10);
      drive_idle();
      #1;
      check("wrap_empty", {31'b0, empty}, 32'd1);

      // async reset with 3 stores pending
      for (int i = 0; i < 3; i++) begin
         st_valid = 1'b1;
         st_addr  = 32'h200 + 32'(i) * 4;
         st_data  = 32'(i);
         cyc();
      end
      drive_idle();
      #1;
      check("pre_rst_we", {31'b0, mem_we}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_we", {31'b0, mem_we}, 32'd0);
      check("mid_rst_empty", {31'b0, empty}, 32'd1);
      #1;
      reset = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("post_rst_we%0d", i), {31'b0, mem_we}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
